// File: rtl/sync_down_counter.sv
// Loadable synchronous binary down counter with wrap or one-shot halt at zero.
// TC is a combinational borrow-out so several stages can share one clock and cascade.
module sync_down_counter #(
    parameter int WIDTH = 4,
    parameter int TOP   = 15
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             E,
    input  logic             LD,
    input  logic [WIDTH-1:0] D,
    input  logic             M,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             DONE
);

    localparam logic [WIDTH-1:0] TOP_VAL = WIDTH'(TOP);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic             q_zero;
    logic [WIDTH-1:0] load_val;

    assign q_zero = (Q == '0);

    // Loads above TOP are clamped so Q can never leave the 0..TOP range.
    assign load_val = (D > TOP_VAL) ? TOP_VAL : D;

    assign TC = E & ~LD & ~M & q_zero;

    // CLR presets/clears the flops directly; LD outranks E.
    // In one-shot mode a zero count simply holds, keeping DONE as it was.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            Q    <= TOP_VAL;
            DONE <= 1'b0;
        end else if (LD) begin
            Q    <= load_val;
            DONE <= 1'b0;
        end else if (E) begin
            if (!q_zero) begin
                Q <= Q - ONE;
                if (M && (Q == ONE)) begin
                    DONE <= 1'b1;
                end
            end else if (!M) begin
                Q <= TOP_VAL;
            end
        end
    end

endmodule

// File: tb/tb_sync_down_counter.sv
// Directed bench for sync_down_counter: a behavioural model checked every cycle,
// plus literal expectations for clamp (TOP=9) and a two-stage cascade.
module tb_sync_down_counter;

    localparam int TOP_A = 15;
    localparam int TOP_B = 9;

    logic       clk;
    logic       clr;
    logic       e, ld, m;
    logic [3:0] d;
    logic [3:0] q;
    logic       tc, done;

    logic       e9, ld9;
    logic [3:0] d9, q9;
    logic       tc9, done9;

    logic       cas_e, cas_ld;
    logic [3:0] d_lo, d_hi, q_lo, q_hi;
    logic       tc_lo, tc_hi, done_lo, done_hi;

    int checks;
    int errors;
    int mq;
    int mdone;
    logic cmp_en;

    sync_down_counter #(.WIDTH(4), .TOP(TOP_A)) dut (
        .CLK(clk), .CLR(clr), .E(e), .LD(ld), .D(d), .M(m),
        .Q(q), .TC(tc), .DONE(done)
    );

    sync_down_counter #(.WIDTH(4), .TOP(TOP_B)) dut_dec (
        .CLK(clk), .CLR(clr), .E(e9), .LD(ld9), .D(d9), .M(1'b0),
        .Q(q9), .TC(tc9), .DONE(done9)
    );

    sync_down_counter #(.WIDTH(4), .TOP(15)) dut_lo (
        .CLK(clk), .CLR(clr), .E(cas_e), .LD(cas_ld), .D(d_lo), .M(1'b0),
        .Q(q_lo), .TC(tc_lo), .DONE(done_lo)
    );

    sync_down_counter #(.WIDTH(4), .TOP(15)) dut_hi (
        .CLK(clk), .CLR(clr), .E(tc_lo), .LD(cas_ld), .D(d_hi), .M(1'b0),
        .Q(q_hi), .TC(tc_hi), .DONE(done_hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic ld_v, input logic e_v, input logic m_v,
                                 input logic [3:0] d_v);
        ld = ld_v;
        e  = e_v;
        m  = m_v;
        d  = d_v;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Counter behaviour straight from the rule table: load clamps, count down,
    // at zero either wrap to TOP or sit there in one-shot mode.
    always @(posedge clk or negedge clr) begin
        if (!clr) begin
            mq    <= TOP_A;
            mdone <= 0;
        end else if (ld) begin
            mq    <= (int'(d) > TOP_A) ? TOP_A : int'(d);
            mdone <= 0;
        end else if (e) begin
            if (mq == 0) begin
                mq <= m ? 0 : TOP_A;
            end else begin
                mq <= mq - 1;
                if (m && mq == 1) mdone <= 1;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            checkOutput("model_q", int'(q), mq);
            checkOutput("model_done", int'(done), mdone);
            checkOutput("model_tc", int'(tc), int'(e && !ld && !m && mq == 0));
        end
    end

    // Drops CLR between edges, holds LD/E high while cleared, then releases.
    task automatic clearMidCycle(input string tag);
        #1 clr = 1'b0;
        #1;
        checkOutput({tag, "_q_immediate"}, int'(q), 15);
        checkOutput({tag, "_done_immediate"}, int'(done), 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd3);
        tick();
        checkOutput({tag, "_q_held"}, int'(q), 15);
        tick();
        clr = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0);
        tick();
        checkOutput({tag, "_q_release"}, int'(q), 15);
    endtask

    initial begin
        logic [3:0] en_seq [4];
        int         en_exp [4];
        en_seq = '{1'b1, 1'b0, 1'b0, 1'b1};
        en_exp = '{9, 9, 9, 8};

        checks = 0;
        errors = 0;
        cmp_en = 1'b0;
        clr    = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0);
        e9 = 1'b0; ld9 = 1'b0; d9 = 4'd0;
        cas_e = 1'b0; cas_ld = 1'b0; d_lo = 4'd0; d_hi = 4'd0;

        #12;
        checkOutput("reset_q", int'(q), 15);
        checkOutput("reset_done", int'(done), 0);
        checkOutput("reset_q_top9", int'(q9), 9);
        checkOutput("reset_cascade", int'({q_hi, q_lo}), 8'hFF);

        @(posedge clk);
        #2;
        clr    = 1'b1;
        cmp_en = 1'b1;

        // Free run in wrap mode.
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd0);
        for (int k = 1; k <= 17; k++) begin
            tick();
            checkOutput("free_run_q", int'(q), (31 - k) % 16);
            if (k == 15) checkOutput("free_run_tc_at_zero", int'(tc), 1);
            if (k == 14) checkOutput("free_run_tc_at_one", int'(tc), 0);
        end

        // Load beats enable; a load while at zero suppresses TC.
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd6);
        tick();
        checkOutput("load_priority_q", int'(q), 6);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd0);
        tick();
        checkOutput("load_zero_q", int'(q), 0);
        checkOutput("load_zero_tc", int'(tc), 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd0);
        #1;
        checkOutput("zero_enabled_tc", int'(tc), 1);
        tick();
        checkOutput("wrap_q", int'(q), 15);

        // One-shot countdown.
        applyStimulus(1'b1, 1'b1, 1'b1, 4'd3);
        tick();
        checkOutput("oneshot_load_q", int'(q), 3);
        applyStimulus(1'b0, 1'b1, 1'b1, 4'd0);
        tick();
        checkOutput("oneshot_q2", int'(q), 2);
        tick();
        checkOutput("oneshot_q1_done", int'(done), 0);
        tick();
        checkOutput("oneshot_q0", int'(q), 0);
        checkOutput("oneshot_done_set", int'(done), 1);
        tick();
        checkOutput("oneshot_hold_q", int'(q), 0);
        checkOutput("oneshot_hold_done", int'(done), 1);
        checkOutput("oneshot_tc", int'(tc), 0);
        applyStimulus(1'b1, 1'b0, 1'b1, 4'd5);
        tick();
        checkOutput("reload_q", int'(q), 5);
        checkOutput("reload_done_cleared", int'(done), 0);
        applyStimulus(1'b1, 1'b0, 1'b1, 4'd0);
        tick();
        checkOutput("load0_done", int'(done), 0);
        applyStimulus(1'b0, 1'b1, 1'b1, 4'd0);
        tick();
        checkOutput("load0_count_done", int'(done), 0);

        // Mode switch with DONE set: DONE sticks, next count wraps.
        applyStimulus(1'b1, 1'b0, 1'b1, 4'd1);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b1, 4'd0);
        tick();
        checkOutput("switch_done_set", int'(done), 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd0);
        tick();
        checkOutput("switch_wrap_q", int'(q), 15);
        checkOutput("switch_done_sticky", int'(done), 1);
        tick();
        tick();
        checkOutput("switch_count_q", int'(q), 13);
        clearMidCycle("clr_done");

        // Enable gating.
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd10);
        tick();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, en_seq[i][0], 1'b0, 4'd0);
            tick();
            checkOutput("enable_gate_q", int'(q), en_exp[i]);
        end

        // Async clear mid-count at Q=4.
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd4);
        tick();
        checkOutput("pre_clear_q", int'(q), 4);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd0);
        clearMidCycle("clr_mid");

        // Clamp and decade wrap with TOP=9.
        ld9 = 1'b1; d9 = 4'd12;
        tick();
        checkOutput("clamp_12", int'(q9), 9);
        d9 = 4'd7;
        tick();
        checkOutput("load_7_top9", int'(q9), 7);
        ld9 = 1'b0; e9 = 1'b1;
        tick();
        checkOutput("count_top9", int'(q9), 6);
        ld9 = 1'b1; d9 = 4'd0;
        tick();
        ld9 = 1'b0;
        tick();
        checkOutput("decade_wrap", int'(q9), 9);
        e9 = 1'b0;

        // Two-stage cascade.
        cas_ld = 1'b1; cas_e = 1'b1; d_hi = 4'h1; d_lo = 4'h0;
        tick();
        checkOutput("cascade_load", int'({q_hi, q_lo}), 8'h10);
        cas_ld = 1'b0;
        tick();
        checkOutput("cascade_borrow", int'({q_hi, q_lo}), 8'h0F);
        tick();
        checkOutput("cascade_step", int'({q_hi, q_lo}), 8'h0E);
        cas_ld = 1'b1; d_hi = 4'h0; d_lo = 4'h0;
        tick();
        checkOutput("cascade_zero", int'({q_hi, q_lo}), 8'h00);
        cas_ld = 1'b0;
        #1;
        checkOutput("cascade_tc_hi", int'(tc_hi), 1);
        tick();
        checkOutput("cascade_wrap", int'({q_hi, q_lo}), 8'hFF);
        cas_e = 1'b0;

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
